// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - sequential A/B/opcode entry from shared switches, debounced ENTER/CLEAR; optional ENTRY_TIMEOUT_EN idle abort
module operand_entry #(
    parameter int N              = 3,
    parameter int DEB_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic [1:0]   op_sw,
    input  logic         btn_enter,
    input  logic         btn_clear,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [1:0]   op,
    output logic         valid,
    output logic [1:0]   step
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } state_t;

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // Index 0 is ENTER, index 1 is CLEAR.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    deb_q, deb_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic          valid_q, valid_d;

    logic          enter_pulse;
    logic          clear_pulse;
    logic          timeout;

    assign btn_raw     = {btn_clear, btn_enter};
    assign enter_pulse = press_q[0];
    assign clear_pulse = press_q[1];

    // Two-stage synchronizer, then a stable-run counter that flips the debounced level
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        press_d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i]   = ~deb_q[i];
                    press_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Button conditioning registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            deb_q   <= 2'b00;
            press_q <= 2'b00;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_q, idle_d;

    // A fresh ENTER in the last idle cycle wins over the abort.
    assign timeout = ((state_q == S_B) || (state_q == S_OP)) &&
                     (idle_q == TO_LAST) && !enter_pulse;

    // Idle counter only runs while parked mid-entry
    always_comb begin
        idle_d = '0;
        if (((state_q == S_B) || (state_q == S_OP)) && !enter_pulse &&
            !clear_pulse && (state_d == state_q)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    // Next state: abort (clear or timeout) beats ENTER
    always_comb begin
        state_d = state_q;
        if (clear_pulse || timeout) begin
            state_d = S_A;
        end else if (enter_pulse) begin
            case (state_q)
                S_A:   state_d = S_B;
                S_B:   state_d = S_OP;
                S_OP:  state_d = S_RUN;
                S_RUN: state_d = S_A;
            endcase
        end
    end

    // Operand capture; values persist across S_RUN -> S_A until overwritten
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clear_pulse || timeout) begin
            a_d  = '0;
            b_d  = '0;
            op_d = 2'b00;
        end else if (enter_pulse) begin
            case (state_q)
                S_A:     a_d  = sw;
                S_B:     b_d  = sw;
                S_OP:    op_d = op_sw;
                default: ;
            endcase
        end
        valid_d = (state_d == S_RUN);
    end

    assign a     = a_q;
    assign b     = b_q;
    assign op    = op_q;
    assign valid = valid_q;
    assign step  = state_q;

endmodule
